xxhash32_stream: RTL and testbench
==================================

# xxhash32_stream

Streaming xxHash32 engine that supersedes the fixed word-only hasher. It adds byte-granular message lengths (1–3 byte tails), valid/ready flow control on input and output, and an internal length counter. A parametrised stripe-commit mode trades area for throughput. It sits between a byte-stream producer and any consumer of 32-bit digests, and it is bit-exact with the xxHash32 C reference for any seed and length.

## Interface
- `STRIPE_PARALLEL`, default 4: rounds per cycle when committing a 16-byte stripe. Legal values are 1 or 4.
- `RESET_SEED`, default 32'h0: seed in effect after reset, until the first `start`.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse. Aborts any message in progress and loads `seed`.
- `seed` in 32: seed value, sampled when `start`=1.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in 32: message bytes, little-endian; `[7:0]` is the earliest byte.
- `in_last` in 1: the beat is the final beat of the message.
- `in_nbytes` in 3: number of valid bytes in the beat (0–4).
  - Honoured only when `in_last`=1. Otherwise it is treated as 4.
  - Values 5–7 are clamped to 4.
  - 0 is legal only on a last beat; it encodes an empty tail or empty message.
- `hash_valid` out 1: digest available.
- `hash_ready` in 1: consumer accepts the digest.
- `hash` out 32: digest, stable while `hash_valid`=1.

## Operation
- Constants: P1=9E3779B1, P2=85EBCA77, P3=C2B2AE3D, P4=27D4EB2F, P5=165667B1. All arithmetic is mod 2^32.
- Init (reset or `start`): v1=s+P1+P2, v2=s+P2, v3=s, v4=s−P1; len=0; word buffer empty. The seed register s keeps its value across messages.
- A beat is accepted when `in_valid`&`in_ready`. Accepting a beat adds its byte count to len, which wraps at 2^32.
- Full words go into a 3-entry buffer. When a full 4-byte word arrives with 3 words already buffered, the stripe commits: vk = rotl(vk + wk·P2, 13)·P1 for k=1..4.
  - A 4th word with fewer than 4 bytes is a tail, not a stripe.
- States:
  - ABSORB: `in_ready`=1.
  - STRIPE: `in_ready`=0.
    - With `STRIPE_PARALLEL`=4, the stripe commits in the accepting cycle and this state is never entered.
    - With `STRIPE_PARALLEL`=1, one lane commits per cycle for 4 cycles, then the block returns to ABSORB, or goes to MERGE if the beat was last.
  - MERGE (1 cycle):
    - If at least one stripe was committed: h = rotl(v1,1)+rotl(v2,7)+rotl(v3,12)+rotl(v4,18).
    - Otherwise: h = s+P5.
    - Then h += len.
  - TAILW: one cycle per buffered full word, oldest first. h = rotl(h+w·P3, 17)·P4.
  - TAILB: one cycle per tail byte of the last beat, low byte first. h = rotl(h+b·P5, 11)·P1.
  - AVAL (1 cycle): h ^= h>>15; h *= P2; h ^= h>>13; h *= P3; h ^= h>>16. The result is registered into `hash`.
  - DONE: `hash_valid`=1 until `hash_ready`=1. Then the block re-initialises with s and returns to ABSORB.
- `start` wins in every state, including when it coincides with an accepted beat. That beat is dropped, and `in_ready` is 0 in the `start` cycle.
- `hash` holds its last digest until the next AVAL, including after a `start`.

## Timing
- Reset values: state ABSORB, `in_ready`=1, `hash_valid`=0, `hash`=0, s=`RESET_SEED`, len=0, buffer empty.
- Throughput:
  - `STRIPE_PARALLEL`=4: 1 beat per cycle.
  - `STRIPE_PARALLEL`=1: 4 beats then 4 stall cycles per stripe.
- Latency from accepting the last beat to `hash_valid`=1 is S+1+W+B+1 cycles:
  - S = 4 if the last beat completes a stripe with `STRIPE_PARALLEL`=1, else 0.
  - W = words left in the buffer.
  - B = tail bytes (0–3).
  - Example: empty message → 2 cycles.
- `hash_valid` falls the cycle after the handshake. `in_ready` rises in that same cycle.
- Asserting `rst_n` mid-message immediately returns all outputs to their reset values.

## Test plan
- Reset, then a single beat with `in_last`=1, `in_nbytes`=0, seed 0 → `hash`=02CC5D05 exactly 2 cycles after acceptance.
- `start` with seed=0, then beat `in_data`=00636261 ("abc"), `in_last`=1, `in_nbytes`=3 → `hash`=32D153FF. Repeat with `in_nbytes`=1 and data 61 ("a") → 550D7456.
- 64-byte, 19-byte and 35-byte messages with seed 9E3779B1, run under both `STRIPE_PARALLEL` values → digests match the C model. With `STRIPE_PARALLEL`=1, `in_ready` drops for exactly 4 cycles after each 4th word.
- Hold `hash_ready`=0 for 10 cycles → `hash_valid` and `hash` stay stable and `in_ready` stays 0. After the handshake, a second message hashes with the retained seed.
- `start` pulsed mid-stripe while `in_valid`=1 → that beat is dropped. The following 3-byte message matches the C model with the new seed.
- `rst_n` pulsed low during TAILW → `hash_valid`=0 and `in_ready`=1. The next empty message yields the digest for `RESET_SEED`.

Source files
------------

// File: rtl/xxhash32_stream_if.sv
// Byte-stream input and digest output channels of xxhash32_stream.
//   in_valid/in_ready/in_data/in_last/in_nbytes : message beats, producer -> hasher
//   hash_valid/hash_ready/hash                   : 32-bit digest, hasher -> consumer
// master: producer/consumer side; slave: the hasher.
interface xxhash32_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        hash_valid;
  logic        hash_ready;
  logic [31:0] hash;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, hash_ready,
    input  in_ready, hash_valid, hash
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, hash_ready,
    output in_ready, hash_valid, hash
  );
endinterface

// File: rtl/xxhash32_stream.sv
// Streaming xxHash32 engine with byte-granular length and valid/ready flow control.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : one-cycle pulse, aborts the current message and loads seed
//   seed       : seed sampled on start
//   bus        : xxhash32_stream_if.slave (input beats and digest output)
// STRIPE_PARALLEL = 4 commits a 16-byte stripe in the accepting cycle;
// STRIPE_PARALLEL = 1 commits one lane per cycle over 4 stall cycles.
module xxhash32_stream #(
  parameter int unsigned STRIPE_PARALLEL = 4,
  parameter logic [31:0] RESET_SEED      = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        seed,
  xxhash32_stream_if.slave   bus
);
  localparam logic [31:0] P1 = 32'h9E3779B1;
  localparam logic [31:0] P2 = 32'h85EBCA77;
  localparam logic [31:0] P3 = 32'hC2B2AE3D;
  localparam logic [31:0] P4 = 32'h27D4EB2F;
  localparam logic [31:0] P5 = 32'h165667B1;

  typedef enum logic [2:0] {ABSORB, STRIPE, MERGE, TAILW, TAILB, AVAL, DONE} state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] lane_round(input logic [31:0] acc, input logic [31:0] w);
    logic [31:0] t;
    t = acc + w * P2;
    return rotl(t, 13) * P1;
  endfunction

  function automatic logic [31:0] avalanche(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x >> 15);
    t = t * P2;
    t = t ^ (t >> 13);
    t = t * P3;
    return t ^ (t >> 16);
  endfunction

  state_t      state, state_nxt;
  logic [31:0] s, len, h, hash_q, tail_w;
  logic [31:0] v    [4];
  logic [31:0] wbuf [4];   // entries 0..2 buffered words; entry 3 holds the 4th stripe word when serial
  logic [1:0]  buf_cnt, tail_n, idx;
  logic        stripe_seen, last_pend;
  logic        in_ready_i, hash_valid_i, acc, full, stripe_fill, do_init;
  logic [2:0]  nb_eff;
  logic [31:0] init_seed;

  // Byte count of the beat: 4 unless last, values above 4 clamp to 4.
  always_comb begin
    nb_eff = 3'd4;
    if (bus.in_last && bus.in_nbytes < 3'd4) nb_eff = bus.in_nbytes;
  end

  assign acc         = bus.in_valid & in_ready_i;
  assign full        = (nb_eff == 3'd4);
  assign stripe_fill = full && (buf_cnt == 2'd3);
  assign do_init     = start || (state == DONE && bus.hash_ready);
  assign init_seed   = start ? seed : s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ABSORB;
    else        state <= state_nxt;
  end

  // Next-state logic; start overrides every state
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ABSORB;
    end else begin
      unique case (state)
        ABSORB: if (acc) begin
          if (stripe_fill && STRIPE_PARALLEL == 1) state_nxt = STRIPE;
          else if (bus.in_last)                    state_nxt = MERGE;
        end
        STRIPE: if (idx == 2'd3) state_nxt = last_pend ? MERGE : ABSORB;
        MERGE:  state_nxt = (buf_cnt != 2'd0) ? TAILW : (tail_n != 2'd0) ? TAILB : AVAL;
        TAILW:  if (idx == buf_cnt - 2'd1) state_nxt = (tail_n != 2'd0) ? TAILB : AVAL;
        TAILB:  if (idx == tail_n - 2'd1)  state_nxt = AVAL;
        AVAL:   state_nxt = DONE;
        DONE:   if (bus.hash_ready) state_nxt = ABSORB;
        default: state_nxt = ABSORB;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready_i   = (state == ABSORB) && !start;
    hash_valid_i = (state == DONE);
  end

  assign bus.in_ready   = in_ready_i;
  assign bus.hash_valid = hash_valid_i;
  assign bus.hash       = hash_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s           <= RESET_SEED;
      v[0]        <= RESET_SEED + P1 + P2;
      v[1]        <= RESET_SEED + P2;
      v[2]        <= RESET_SEED;
      v[3]        <= RESET_SEED - P1;
      len         <= '0;
      buf_cnt     <= '0;
      tail_n      <= '0;
      idx         <= '0;
      stripe_seen <= 1'b0;
      last_pend   <= 1'b0;
      tail_w      <= '0;
      h           <= '0;
      hash_q      <= '0;
      for (int unsigned i = 0; i < 4; i++) wbuf[i] <= '0;
    end else if (do_init) begin
      s           <= init_seed;
      v[0]        <= init_seed + P1 + P2;
      v[1]        <= init_seed + P2;
      v[2]        <= init_seed;
      v[3]        <= init_seed - P1;
      len         <= '0;
      buf_cnt     <= '0;
      tail_n      <= '0;
      idx         <= '0;
      stripe_seen <= 1'b0;
      last_pend   <= 1'b0;
    end else begin
      unique case (state)
        ABSORB: if (acc) begin
          len <= len + {29'd0, nb_eff};
          if (stripe_fill) begin
            tail_n <= '0;
            if (STRIPE_PARALLEL == 1) begin
              wbuf[3]   <= bus.in_data;
              last_pend <= bus.in_last;
            end else begin
              v[0]        <= lane_round(v[0], wbuf[0]);
              v[1]        <= lane_round(v[1], wbuf[1]);
              v[2]        <= lane_round(v[2], wbuf[2]);
              v[3]        <= lane_round(v[3], bus.in_data);
              buf_cnt     <= '0;
              stripe_seen <= 1'b1;
            end
          end else if (full) begin
            wbuf[buf_cnt] <= bus.in_data;
            buf_cnt       <= buf_cnt + 2'd1;
            tail_n        <= '0;
          end else begin
            tail_w <= bus.in_data;
            tail_n <= nb_eff[1:0];
          end
        end
        STRIPE: begin
          v[idx] <= lane_round(v[idx], wbuf[idx]);
          idx    <= idx + 2'd1;
          if (idx == 2'd3) begin
            buf_cnt     <= '0;
            stripe_seen <= 1'b1;
          end
        end
        MERGE: begin
          h   <= (stripe_seen ? rotl(v[0], 1) + rotl(v[1], 7) + rotl(v[2], 12) + rotl(v[3], 18)
                              : s + P5) + len;
          idx <= '0;
        end
        TAILW: begin
          h   <= rotl(h + wbuf[idx] * P3, 17) * P4;
          idx <= (idx == buf_cnt - 2'd1) ? 2'd0 : idx + 2'd1;
        end
        TAILB: begin
          h   <= rotl(h + {24'd0, tail_w[{idx, 3'b000} +: 8]} * P5, 11) * P1;
          idx <= (idx == tail_n - 2'd1) ? 2'd0 : idx + 2'd1;
        end
        AVAL: hash_q <= avalanche(h);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xxhash32_stream.sv
module tb_xxhash32_stream;
  localparam logic [31:0] P1 = 32'h9E3779B1;
  localparam logic [31:0] P2 = 32'h85EBCA77;
  localparam logic [31:0] P3 = 32'hC2B2AE3D;
  localparam logic [31:0] P4 = 32'h27D4EB2F;
  localparam logic [31:0] P5 = 32'h165667B1;
  localparam logic [31:0] RESET_A = 32'h0BAD5EED;

  typedef struct {
    bit          sel;       // 0: parallel DUT, 1: serial DUT
    bit          do_start;
    logic [31:0] seed;
    int unsigned len;
    bit          pat;       // 0: "abc..." text, 1: pseudo-random bytes
    bit          zt;        // message ends with an extra 0-byte last beat
    bit          clamp;     // full last beat sent with in_nbytes=7
    bit          use_fixed;
    logic [31:0] fixed;
  } vec_t;

  typedef struct { logic [31:0] h; int acc; int lat; } exp_t;

  logic clk, rst_n;
  logic drv_valid, drv_last, drv_start, hr;
  logic [31:0] drv_data, seed_d;
  logic [2:0]  drv_nb;
  logic start_a, start_b;
  bit   sel;
  logic [7:0] msg [0:127];
  exp_t q[$];
  vec_t vecs[17];
  int   cyc, rise, errors, checks;
  bit   hv_q, rdy_s;

  xxhash32_stream_if ifa ();
  xxhash32_stream_if ifb ();

  assign ifa.in_valid   = drv_valid & ~sel;
  assign ifb.in_valid   = drv_valid &  sel;
  assign ifa.in_data    = drv_data;
  assign ifb.in_data    = drv_data;
  assign ifa.in_last    = drv_last;
  assign ifb.in_last    = drv_last;
  assign ifa.in_nbytes  = drv_nb;
  assign ifb.in_nbytes  = drv_nb;
  assign ifa.hash_ready = hr & ~sel;
  assign ifb.hash_ready = hr &  sel;
  assign start_a        = drv_start & ~sel;
  assign start_b        = drv_start &  sel;

  wire        rdy_m  = sel ? ifb.in_ready   : ifa.in_ready;
  wire        hv_m   = sel ? ifb.hash_valid : ifa.hash_valid;
  wire [31:0] hash_m = sel ? ifb.hash       : ifa.hash;

  xxhash32_stream #(.STRIPE_PARALLEL(4), .RESET_SEED(RESET_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .seed(seed_d), .bus(ifa));
  xxhash32_stream #(.STRIPE_PARALLEL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .seed(seed_d), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int unsigned r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [31:0] rd32(input int unsigned p);
    return {msg[p+3], msg[p+2], msg[p+1], msg[p]};
  endfunction

  // Reference xxHash32 over msg[0..n-1]
  function automatic logic [31:0] model(input logic [31:0] sd, input int unsigned n);
    logic [31:0] a1, a2, a3, a4, h, w;
    int unsigned p = 0;
    if (n >= 16) begin
      a1 = sd + P1 + P2; a2 = sd + P2; a3 = sd; a4 = sd - P1;
      while (p + 16 <= n) begin
        a1 = rl(a1 + rd32(p)      * P2, 13) * P1;
        a2 = rl(a2 + rd32(p + 4)  * P2, 13) * P1;
        a3 = rl(a3 + rd32(p + 8)  * P2, 13) * P1;
        a4 = rl(a4 + rd32(p + 12) * P2, 13) * P1;
        p += 16;
      end
      h = rl(a1, 1) + rl(a2, 7) + rl(a3, 12) + rl(a4, 18);
    end else begin
      h = sd + P5;
    end
    h = h + n;
    while (p + 4 <= n) begin
      w = rd32(p);
      h = rl(h + w * P3, 17) * P4;
      p += 4;
    end
    while (p < n) begin
      w = {24'd0, msg[p]};
      h = rl(h + w * P5, 11) * P1;
      p++;
    end
    h = h ^ (h >> 15); h = h * P2;
    h = h ^ (h >> 13); h = h * P3;
    h = h ^ (h >> 16);
    return h;
  endfunction

  function automatic int lat_of(input bit s1, input int unsigned n, input bit zt);
    int w;
    w = int'((n % 16) / 4);
    if (zt) return 2 + w;
    return ((s1 && n > 0 && n % 16 == 0) ? 4 : 0) + 2 + w + int'(n % 4);
  endfunction

  task automatic fill(input bit pat);
    for (int unsigned i = 0; i < 128; i++) msg[i] = pat ? 8'((i * 37 + 11) & 8'hFF) : 8'(8'h61 + i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Scoreboard side: pop and compare when a digest handshake is about to occur
  task automatic mon();
    exp_t e;
    if (hv_m && !hv_q) rise = cyc;
    hv_q = hv_m;
    if (hv_m && hr) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_digest: got %h expected none", hash_m);
      end else begin
        e = q.pop_front();
        chk("digest", hash_m, e.h);
        chk("latency", 32'(rise - e.acc), 32'(e.lat));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    rdy_s = rdy_m;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input logic [2:0] nb,
                           output int stalls, output bit ok);
    drv_valid = 1'b1; drv_data = d; drv_last = last; drv_nb = nb;
    stalls = 0; ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (rdy_s) ok = 1'b1; else stalls++;
    end
    drv_valid = 1'b0; drv_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 50 cycles");
    end
  endtask

  task automatic pulse_start(input logic [31:0] sd);
    drv_start = 1'b1; seed_d = sd;
    tick();
    chk("in_ready_during_start", 32'(rdy_s), 32'd0);
    drv_start = 1'b0;
  endtask

  task automatic send_msg(input logic [31:0] sd, input int unsigned n, input bit do_start,
                          input bit zt, input bit clamp, input bit expect_out,
                          input logic [31:0] exp_h, input int lat);
    int unsigned fw, tl, nbeats;
    int stalls;
    bit last, ok;
    logic [31:0] d;
    logic [2:0] nb;
    if (do_start) pulse_start(sd);
    fw = n / 4; tl = n % 4;
    nbeats = (zt || tl != 0 || n == 0) ? fw + 1 : fw;
    for (int unsigned b = 0; b < nbeats; b++) begin
      last = (b == nbeats - 1);
      if (b < fw) d = rd32(4 * b);
      else begin
        d = 32'hEEEEEEEE;
        for (int unsigned k = 0; k < tl; k++) d[8*k +: 8] = msg[4*b + k];
      end
      if (!last)      nb = 3'd2;
      else if (b < fw) nb = clamp ? 3'd7 : 3'd4;
      else            nb = 3'(tl);
      send_beat(d, last, nb, stalls, ok);
      if (ok) chk("stall_cycles", 32'(stalls), (sel && b > 0 && b % 4 == 0) ? 32'd4 : 32'd0);
      if (ok && last && expect_out) q.push_back('{exp_h, cyc, lat});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [31:0] held, exp_h;
    int stalls;
    bit ok;
    errors = 0; checks = 0; cyc = 0; rise = 0; hv_q = 1'b0; rdy_s = 1'b0;
    rst_n = 1'b0; drv_valid = 1'b0; drv_last = 1'b0; drv_start = 1'b0;
    drv_data = '0; drv_nb = '0; seed_d = '0; hr = 1'b1; sel = 1'b0;

    //            sel   start seed          len pat  zt   clamp fixed
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h02CC5D05};
    vecs[1]  = '{1'b0, 1'b1, 32'h0,         3,  1'b0, 1'b0, 1'b0, 1'b1, 32'h32D153FF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0,         1,  1'b0, 1'b0, 1'b0, 1'b1, 32'h550D7456};
    vecs[3]  = '{1'b1, 1'b1, 32'h0,         3,  1'b0, 1'b0, 1'b0, 1'b1, 32'h32D153FF};
    vecs[4]  = '{1'b0, 1'b1, 32'h9E3779B1, 64,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h9E3779B1, 64,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h9E3779B1, 19,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'h9E3779B1, 19,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h9E3779B1, 35,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h9E3779B1, 35,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h9E3779B1, 27,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h9E3779B1, 27,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h12345678, 20,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 32'h12345678, 16,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 32'hDEADBEEF,  8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'hDEADBEEF, 32,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 32'hFFFFFFFF,  0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready_a",   32'(ifa.in_ready),   32'd1);
    chk("reset_hash_valid_a", 32'(ifa.hash_valid), 32'd0);
    chk("reset_hash_a",       ifa.hash,            32'd0);
    chk("reset_in_ready_b",   32'(ifb.in_ready),   32'd1);
    chk("reset_hash_valid_b", 32'(ifb.hash_valid), 32'd0);
    chk("reset_hash_b",       ifb.hash,            32'd0);

    for (int unsigned i = 0; i < 17; i++) begin
      sel = vecs[i].sel;
      fill(vecs[i].pat);
      exp_h = vecs[i].use_fixed ? vecs[i].fixed : model(vecs[i].seed, vecs[i].len);
      send_msg(vecs[i].seed, vecs[i].len, vecs[i].do_start, vecs[i].zt, vecs[i].clamp, 1'b1,
               exp_h, lat_of(vecs[i].sel, vecs[i].len, vecs[i].zt));
      drain();
    end

    // Digest back-pressure, then a second message on the retained seed
    sel = 1'b0; fill(1'b0); hr = 1'b0;
    send_msg(32'h13579BDF, 3, 1'b1, 1'b0, 1'b0, 1'b1, model(32'h13579BDF, 3), 5);
    for (int i = 0; i < 20 && !hv_m; i++) tick();
    chk("hold_valid_rise", 32'(hv_m), 32'd1);
    held = hash_m;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(hv_m), 32'd1);
      chk("hold_hash", hash_m, held);
      chk("hold_in_ready", 32'(rdy_m), 32'd0);
    end
    hr = 1'b1;
    drain();
    chk("post_handshake_valid", 32'(hv_m), 32'd0);
    chk("post_handshake_ready", 32'(rdy_m), 32'd1);
    fill(1'b1);
    send_msg(32'h0, 19, 1'b0, 1'b0, 1'b0, 1'b1, model(32'h13579BDF, 19), 5);
    drain();

    // Serial DUT: start pulsed during STRIPE with a beat offered
    sel = 1'b1; fill(1'b1);
    pulse_start(32'h9E3779B1);
    for (int unsigned b = 0; b < 4; b++) send_beat(rd32(4 * b), 1'b0, 3'd4, stalls, ok);
    held = hash_m;
    drv_valid = 1'b1; drv_data = 32'hCAFEF00D; drv_last = 1'b1; drv_nb = 3'd0;
    drv_start = 1'b1; seed_d = 32'hA1B2C3D4;
    tick();
    chk("abort_stripe_ready", 32'(rdy_s), 32'd0);
    drv_start = 1'b0; drv_valid = 1'b0; drv_last = 1'b0;
    chk("hash_kept_after_start", hash_m, held);
    send_msg(32'h0, 3, 1'b0, 1'b0, 1'b0, 1'b1, model(32'hA1B2C3D4, 3), 5);
    drain();

    // Parallel DUT: start coincides with an offered last beat in ABSORB
    sel = 1'b0;
    pulse_start(32'h55AA55AA);
    for (int unsigned b = 0; b < 2; b++) send_beat(rd32(4 * b), 1'b0, 3'd4, stalls, ok);
    drv_valid = 1'b1; drv_data = 32'h01020304; drv_last = 1'b1; drv_nb = 3'd0;
    drv_start = 1'b1; seed_d = 32'h76543210;
    tick();
    chk("abort_absorb_ready", 32'(rdy_s), 32'd0);
    drv_start = 1'b0; drv_valid = 1'b0; drv_last = 1'b0;
    send_msg(32'h0, 3, 1'b0, 1'b0, 1'b0, 1'b1, model(32'h76543210, 3), 5);
    drain();

    // Reset asserted during TAILW, then empty message on the reset seed
    sel = 1'b0;
    send_msg(32'h31415926, 27, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(rdy_m), 32'd1);
    chk("rst_hash_valid", 32'(hv_m), 32'd0);
    chk("rst_hash", hash_m, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_msg(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, model(RESET_A, 0), 2);
    drain();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
